// File: rtl/mem_dump_uart.sv
// mem_dump_uart: streams a block of the 21-bit external memory space back to
// the host as 8N1 UART frames, followed by an 8-bit additive checksum byte.
// Owns the external bus only while the GB core is held in reset.
module mem_dump_uart #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned READ_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [20:0] start_adr,
    input  logic [20:0] length,
    output logic [20:0] adr,
    output logic        read,
    input  logic [7:0]  din,
    input  logic        n_cts,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned WAIT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAITCTS,
        SEND,
        CSUM,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         cts_sync;
    logic               cts;
    logic [20:0]        adr_cnt;
    logic [20:0]        adr_hold;
    logic [20:0]        remaining;
    logic [7:0]         csum;
    logic [7:0]         shreg;
    logic               is_csum;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [3:0]         bit_cnt;
    logic               read_last;
    logic               baud_last;
    logic               frame_end;

    assign cts       = cts_sync[1];
    assign read_last = (wait_cnt == WAIT_LAST);
    assign baud_last = (baud_cnt == BAUD_LAST);
    assign frame_end = baud_last && (bit_cnt == 4'd9);

    // Two-flop synchroniser for the asynchronous host flow-control input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cts_sync <= '1;
        end else begin
            cts_sync <= {cts_sync[0], n_cts};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and outputs; tx is forced high outside SEND so a reset
    // mid-frame returns the line to idle without waiting for a clock
    always_comb begin
        state_nx = state;
        read     = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        tx       = 1'b1;
        adr      = adr_hold;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nx = (length != '0) ? READ : CSUM;
                end
            end
            READ: begin
                read = 1'b1;
                adr  = adr_cnt;
                if (read_last) begin
                    state_nx = WAITCTS;
                end
            end
            WAITCTS: begin
                if (!cts) begin
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (bit_cnt == 4'd0) begin
                    tx = 1'b0;
                end else if (bit_cnt == 4'd9) begin
                    tx = 1'b1;
                end else begin
                    tx = shreg[0];
                end
                if (frame_end) begin
                    if (is_csum) begin
                        state_nx = DONE;
                    end else if (remaining != 21'd1) begin
                        state_nx = READ;
                    end else begin
                        state_nx = CSUM;
                    end
                end
            end
            CSUM: begin
                state_nx = WAITCTS;
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Datapath: address/count capture, read sampling, checksum and bit timing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_cnt   <= '0;
            adr_hold  <= '0;
            remaining <= '0;
            csum      <= '0;
            shreg     <= '0;
            is_csum   <= 1'b0;
            wait_cnt  <= '0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (start) begin
                        adr_cnt   <= start_adr;
                        remaining <= length;
                        csum      <= '0;
                        is_csum   <= 1'b0;
                    end
                end
                READ: begin
                    adr_hold <= adr_cnt;
                    if (read_last) begin
                        wait_cnt <= '0;
                        shreg    <= din;
                        csum     <= csum + din;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                WAITCTS: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                end
                SEND: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if ((bit_cnt >= 4'd1) && (bit_cnt <= 4'd8)) begin
                            shreg <= {1'b0, shreg[7:1]};
                        end
                        if (bit_cnt == 4'd9) begin
                            bit_cnt <= '0;
                            if (!is_csum) begin
                                adr_cnt   <= adr_cnt + 21'd1;
                                remaining <= remaining - 21'd1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                CSUM: begin
                    shreg   <= csum;
                    is_csum <= 1'b1;
                end
                default: begin
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule
